// File: rtl/clkdiv_pkg.sv
// rtl/clkdiv_pkg.sv - shared state type, ratio floor and clamp helper for clkdiv_drv
package clkdiv_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } clkdiv_state_e;

   localparam logic [31:0] DIV_MIN = 32'd2;

   // Ratios below DIV_MIN cannot form a high and a low phase, so they are lifted to it.
   function automatic logic [31:0] div_clamp(input logic [31:0] val);
      return (val < DIV_MIN) ? DIV_MIN : val;
   endfunction

endpackage

// File: rtl/clkdiv_phase_cnt.sv
// rtl/clkdiv_phase_cnt.sv - period counter with end-of-period and high-phase compare
module clkdiv_phase_cnt
   import clkdiv_pkg::*;
#(
   parameter int DIV_W = 8
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [DIV_W-1:0] i_n_act,
   input  logic             i_restart,
   output logic             o_cnt_last,
   output logic             o_phase_hi
);

   logic [DIV_W-1:0] r_cnt;
   logic [DIV_W:0]   w_cnt_nxt;
   logic [DIV_W:0]   w_half;

   // One extra bit keeps ceil(N/2) and cnt+1 exact at the top of the ratio range.
   assign w_cnt_nxt  = (DIV_W+1)'(r_cnt) + (DIV_W+1)'(1);
   assign w_half     = ((DIV_W+1)'(i_n_act) + (DIV_W+1)'(1)) >> 1;
   assign o_cnt_last = (w_cnt_nxt == (DIV_W+1)'(i_n_act));
   assign o_phase_hi = (w_cnt_nxt < w_half);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
      end else if (i_restart || o_cnt_last) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= w_cnt_nxt[DIV_W-1:0];
      end
   end

endmodule

// File: rtl/clkdiv_drv.sv
// rtl/clkdiv_drv.sv - glitch-free programmable divider driving the buf_16 clock buffer
module clkdiv_drv
   import clkdiv_pkg::*;
#(
   parameter int DIV_W   = 8,
   parameter int DIV_RST = 2
) (
   input  logic             CLK,
   input  logic             RN,
   input  logic             en,
   input  logic [DIV_W-1:0] div_val,
   input  logic             div_load,
   output logic             div_ack,
   output logic             clk_out,
   output logic             period_tick,
   output logic             busy
);

   clkdiv_state_e    r_state;
   logic [DIV_W-1:0] r_n_act;
   logic [DIV_W-1:0] r_n_pend;
   logic             r_pend_v;
   logic             r_clk_out;
   logic             r_tick;
   logic             r_ack;
   logic             r_busy;

   logic [DIV_W-1:0] w_load_val;
   logic             w_cnt_last;
   logic             w_phase_hi;

   assign w_load_val = DIV_W'(div_clamp(32'(div_val)));

   clkdiv_phase_cnt #(
      .DIV_W (DIV_W)
   ) u_phase_cnt (
      .i_clk      (CLK),
      .i_rst_n    (RN),
      .i_n_act    (r_n_act),
      .i_restart  (r_state == IDLE),
      .o_cnt_last (w_cnt_last),
      .o_phase_hi (w_phase_hi)
   );

   always_ff @(posedge CLK or negedge RN) begin
      if (!RN) begin
         r_state   <= IDLE;
         r_n_act   <= DIV_W'(DIV_RST);
         r_n_pend  <= '0;
         r_pend_v  <= 1'b0;
         r_clk_out <= 1'b0;
         r_tick    <= 1'b0;
         r_ack     <= 1'b0;
         r_busy    <= 1'b0;
      end else begin
         r_ack  <= div_load;
         r_tick <= 1'b0;
         case (r_state)
            IDLE: begin
               r_clk_out <= 1'b0;
               if (div_load) begin
                  r_n_act <= w_load_val;
               end
               if (en) begin
                  r_state   <= RUN;
                  r_clk_out <= 1'b1;
                  r_tick    <= 1'b1;
                  r_busy    <= 1'b1;
               end
            end
            RUN: begin
               if (w_cnt_last) begin
                  if (r_pend_v) begin
                     r_n_act  <= r_n_pend;
                     r_pend_v <= 1'b0;
                  end
                  if (!en) begin
                     r_state   <= IDLE;
                     r_clk_out <= 1'b0;
                     r_busy    <= 1'b0;
                  end else begin
                     r_clk_out <= 1'b1;
                     r_tick    <= 1'b1;
                  end
               end else begin
                  r_clk_out <= w_phase_hi;
               end
               // A load in the boundary cycle lands here after the old pending value was consumed.
               if (div_load) begin
                  r_n_pend <= w_load_val;
                  r_pend_v <= 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // buf_16 input sits directly on this flop.
   assign clk_out     = r_clk_out;
   assign period_tick = r_tick;
   assign div_ack     = r_ack;
   assign busy        = r_busy;

endmodule

// File: tb/tb_clkdiv_drv.sv
// tb/tb_clkdiv_drv.sv - scoreboard bench for clkdiv_drv against a period-waveform model
module tb_clkdiv_drv;

   localparam int DIV_RST = 2;

   logic       CLK;
   logic       RN;
   logic       en;
   logic [7:0] div_val;
   logic       div_load;
   logic       div_ack;
   logic       clk_out;
   logic       period_tick;
   logic       busy;

   clkdiv_drv #(
      .DIV_W   (8),
      .DIV_RST (DIV_RST)
   ) dut (
      .CLK         (CLK),
      .RN          (RN),
      .en          (en),
      .div_val     (div_val),
      .div_load    (div_load),
      .div_ack     (div_ack),
      .clk_out     (clk_out),
      .period_tick (period_tick),
      .busy        (busy)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct packed {
      logic clk;
      logic tick;
      logic busy;
      logic ack;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_errors = 0;

   // Model: the current period is a queue of remaining clk_out levels.
   bit          m_run;
   int unsigned m_n_act;
   int unsigned m_n_pend;
   bit          m_pend_v;
   int unsigned m_n_cur;
   bit          m_wave[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_run    = 1'b0;
      m_n_act  = DIV_RST;
      m_n_pend = 0;
      m_pend_v = 1'b0;
      m_n_cur  = 0;
      m_wave.delete();
   endfunction

   function automatic void start_period();
      m_wave.delete();
      m_n_cur = m_n_act;
      for (int i = 0; i < int'(m_n_act); i++) m_wave.push_back(i < int'((m_n_act + 1) / 2));
   endfunction

   function automatic int model_pos();
      return int'(m_n_cur) - m_wave.size();
   endfunction

   function automatic void model_step(input bit e, input bit ld, input logic [7:0] v);
      int unsigned nv;
      exp_t x;
      nv = (v < 2) ? 2 : int'(v);
      x.tick = 1'b0;
      x.ack  = ld;
      if (!m_run) begin
         if (ld) m_n_act = nv;
         if (e) begin
            m_run = 1'b1;
            start_period();
            x.tick = 1'b1;
         end
      end else begin
         if (m_wave.size() == 1) begin
            if (m_pend_v) begin
               m_n_act  = m_n_pend;
               m_pend_v = 1'b0;
            end
            if (e) begin
               start_period();
               x.tick = 1'b1;
            end else begin
               m_run = 1'b0;
               m_wave.delete();
            end
         end else begin
            void'(m_wave.pop_front());
         end
         if (ld) begin
            m_n_pend = nv;
            m_pend_v = 1'b1;
         end
      end
      x.clk  = m_run ? m_wave[0] : 1'b0;
      x.busy = m_run;
      sb.push_back(x);
   endfunction

   always @(negedge CLK) begin
      if (sb.size() > 0) begin
         exp_t x;
         x = sb.pop_front();
         chk("clk_out", clk_out, x.clk);
         chk("period_tick", period_tick, x.tick);
         chk("busy", busy, x.busy);
         chk("div_ack", div_ack, x.ack);
      end
   end

   task automatic cycle(input bit e, input bit ld, input logic [7:0] v);
      en       = e;
      div_load = ld;
      div_val  = v;
      @(posedge CLK);
      model_step(e, ld, v);
      @(negedge CLK);
   endtask

   task automatic wait_pos(input int p);
      int k = 0;
      while (!(m_run && model_pos() == p) && k < 300) begin
         cycle(1'b1, 1'b0, 8'd0);
         k++;
      end
      if (k >= 300) begin
         n_checks++;
         n_errors++;
         $display("FAIL wait_pos timeout actual=%0d expected=%0d", model_pos(), p);
      end
   endtask

   task automatic go_idle();
      int k = 0;
      while (m_run && k < 300) begin
         cycle(1'b0, 1'b0, 8'd0);
         k++;
      end
      if (k >= 300) begin
         n_checks++;
         n_errors++;
         $display("FAIL go_idle timeout actual=%0d expected=%0d", m_run, 0);
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 8'd0);
   endtask

   initial begin
      RN       = 1'b0;
      en       = 1'b0;
      div_load = 1'b0;
      div_val  = 8'd0;
      model_reset();
      repeat (2) @(posedge CLK);
      #1;
      chk("rst clk_out", clk_out, 0);
      chk("rst period_tick", period_tick, 0);
      chk("rst busy", busy, 0);
      chk("rst div_ack", div_ack, 0);
      @(negedge CLK);
      RN = 1'b1;

      run(10);

      go_idle();
      cycle(1'b0, 1'b1, 8'd5);
      run(14);

      go_idle();
      cycle(1'b0, 1'b1, 8'd4);
      run(4);
      wait_pos(1);
      cycle(1'b1, 1'b1, 8'd7);
      wait_pos(2);
      cycle(1'b1, 1'b1, 8'd3);
      run(12);

      cycle(1'b1, 1'b1, 8'd4);
      run(8);
      wait_pos(3);
      cycle(1'b1, 1'b1, 8'd6);
      run(16);

      go_idle();
      cycle(1'b0, 1'b1, 8'd0);
      run(6);
      cycle(1'b1, 1'b1, 8'd1);
      run(8);

      go_idle();
      cycle(1'b0, 1'b1, 8'd8);
      wait_pos(1);
      for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 8'd0);

      run(1);
      wait_pos(2);
      #2 RN = 1'b0;
      sb.delete();
      #1;
      chk("async clk_out", clk_out, 0);
      chk("async busy", busy, 0);
      chk("async period_tick", period_tick, 0);
      chk("async div_ack", div_ack, 0);
      @(posedge CLK);
      @(negedge CLK);
      RN = 1'b1;
      model_reset();
      run(6);

      for (int i = 0; i < 1500; i++) begin
         int unsigned r;
         logic [7:0]  v;
         r = $urandom_range(0, 15);
         v = (r == 15) ? 8'($urandom_range(0, 255)) : 8'(r);
         cycle($urandom_range(0, 9) != 0, $urandom_range(0, 7) == 0, v);
      end

      go_idle();
      run(0);
      @(negedge CLK);
      #1;
      chk("scoreboard drained", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
